// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer feeding the HI/LO register pair.
// Operates on operand magnitudes. A shift-add multiply or restoring divide runs for WIDTH
// cycles, then a FIXUP cycle applies the signs and a DONE cycle pulses hilo_we.
// Optional build macro MULDIV_EARLY_OUT_EN ends a multiply once the remaining multiplier is 0.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; operands latched on the start cycle
// S_MUL   | one shift-add step per cycle
// S_DIV   | one restoring quotient bit per cycle, MSB first
// S_FIXUP | sign correction of product / quotient / remainder
// S_DONE  | hilo_we pulse, hilo_wd valid
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    input  logic               mf_req,
    output logic               busy,
    output logic               stall,
    output logic               hilo_we,
    output logic [2*WIDTH-1:0] hilo_wd,
    output logic               div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

    state_t             state, state_nx;
    logic               op_div;
    logic               res_neg;
    logic               rem_neg;
    logic               dbz_q;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;

    // op[1] selects divide, op[0] selects unsigned
    logic               sgn_in;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               last_iter;
    logic               mul_last;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [2*WIDTH-1:0] result;

    assign sgn_in    = ~op[0];
    assign a_neg     = sgn_in & srca[WIDTH-1];
    assign b_neg     = sgn_in & srcb[WIDTH-1];
    assign a_mag     = a_neg ? -srca : srca;
    assign b_mag     = b_neg ? -srcb : srcb;
    assign last_iter = (cnt == CW'(WIDTH-1));

`ifdef MULDIV_EARLY_OUT_EN
    // leave after the step that shifts the last set multiplier bit out
    assign mul_last  = last_iter | ((opb >> 1) == '0);
`else
    assign mul_last  = last_iter;
`endif

    // restoring step: remainder with next dividend bit shifted in, minus divisor
    assign partial   = acc[2*WIDTH-1:WIDTH-1];
    assign diff      = partial - {1'b0, opb};
    assign qbit      = ~diff[WIDTH];

    assign busy        = (state != S_IDLE);
    assign stall       = busy & (mf_req | start);
    assign hilo_we     = (state == S_DONE);
    assign div_by_zero = (state == S_DONE) & dbz_q;

    // sign correction; a zero divisor keeps the all-ones quotient un-negated
    always_comb begin
        result = acc;
        if (!op_div) begin
            if (res_neg)
                result = -acc;
        end else begin
            if (res_neg && !dbz_q)
                result[WIDTH-1:0] = -acc[WIDTH-1:0];
            if (rem_neg)
                result[2*WIDTH-1:WIDTH] = -acc[2*WIDTH-1:WIDTH];
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // next-state logic; a start while busy is simply dropped
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = op[1] ? S_DIV : S_MUL;
            S_MUL:   if (mul_last) state_nx = S_FIXUP;
            S_DIV:   if (last_iter) state_nx = S_FIXUP;
            S_FIXUP: state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // datapath: operand latch, iteration, and result capture into hilo_wd
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dbz_q   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            opb     <= '0;
            hilo_wd <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_div  <= op[1];
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        dbz_q   <= op[1] & (srcb == '0);
                        cnt     <= '0;
                        opb     <= b_mag;
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                        end
                    end
                end
                S_MUL: begin
                    if (opb[0])
                        acc <= acc + mcand;
                    mcand <= mcand << 1;
                    opb   <= opb >> 1;
                    cnt   <= cnt + CW'(1);
                end
                S_DIV: begin
                    acc <= {(qbit ? diff[WIDTH-1:0] : partial[WIDTH-1:0]),
                            acc[WIDTH-2:0], qbit};
                    cnt <= cnt + CW'(1);
                end
                S_FIXUP: hilo_wd <= result;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random multiply/divide operations with a result scoreboard.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mf_req;
    logic        busy;
    logic        stall;
    logic        hilo_we;
    logic [63:0] hilo_wd;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .mf_req(mf_req), .busy(busy), .stall(stall), .hilo_we(hilo_we),
        .hilo_wd(hilo_wd), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
        int          hb;
        logic [31:0] mag;
        hb  = 0;
        mag = (!o[0] && b[31]) ? -b : b;
        for (int i = 0; i < 32; i++)
            if (mag[i]) hb = i;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) return hb + 3;
`endif
        return 34;
    endfunction

    // launches one op at cycle 0, follows it to DONE and checks result, latency and busy
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] ewd, input logic edbz,
                          input int intf_at);
        int          n;
        int          elat;
        logic [64:0] e;
        elat = exp_lat(o, b);
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        exp_q.push_back({edbz, ewd});
        @(negedge clk);
        start = 1'b0; srca = $urandom; srcb = $urandom; op = 2'($urandom_range(0, 3));
        n = 1;
        check({tag, " busy_c1"}, 64'(busy), 64'd1);
        while (!hilo_we && n < 100) begin
            if (n == intf_at) begin
                start = 1'b1; mf_req = 1'b1; op = 2'b01; srca = 32'd9; srcb = 32'd9;
                #1;
                check({tag, " stall_busy"}, 64'(stall), 64'd1);
            end
            @(negedge clk);
            start = 1'b0; mf_req = 1'b0;
            n++;
        end
        check({tag, " we_seen"}, 64'(hilo_we), 64'd1);
        check({tag, " latency"}, 64'(n), 64'(elat));
        check({tag, " busy_done"}, 64'(busy), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " hilo_wd"}, hilo_wd, e[63:0]);
            check({tag, " dbz"}, 64'(div_by_zero), 64'(e[64]));
        end else begin
            check({tag, " scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
        end
        @(negedge clk);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " we_after"}, 64'(hilo_we), 64'd0);
        check({tag, " wd_held"}, hilo_wd, ewd);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        logic [64:0] m;
        int          we_cnt;

        reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0; mf_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst we", 64'(hilo_we), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);
        check("rst wd", hilo_wd, 64'd0);
        reset = 1'b0;

        mf_req = 1'b1; #1;
        check("idle stall", 64'(stall), 64'd0);
        mf_req = 1'b0;

        run_op("multu7x6", 2'b01, 32'd7, 32'd6, 64'h0000_0000_0000_002A, 1'b0, 0);
        run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0, 0);
        run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 0);
        run_op("divu100_7", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 0);
        run_op("divu_by0", 2'b11, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, 0);
        run_op("div_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1, 0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 0);
        run_op("multu3x5", 2'b01, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, 0);
        run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0, 0);
        run_op("busy_start", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0, 10);

        // reset mid-divide: abort, no write ever follows
        @(negedge clk);
        start = 1'b1; op = 2'b11; srca = 32'd1000; srcb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 15; i++) @(negedge clk);
        check("abort busy_pre", 64'(busy), 64'd1);
        reset = 1'b1; #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort we", 64'(hilo_we), 64'd0);
        check("abort wd", hilo_wd, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hilo_we) we_cnt++;
        end
        check("abort no_we", 64'(we_cnt), 64'd0);
        run_op("post_abort", 2'b11, 32'd1000, 32'd3, 64'h00000001_0000014D, 1'b0, 0);

        for (int k = 0; k < 10; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (k % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            m  = model(ro, ra, rb);
            run_op($sformatf("rand%0d", k), ro, ra, rb, m[63:0], m[64], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
